// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard control slice.
//   FWD_RF / FWD_W / FWD_M : E-stage ALU operand forward selects
//   md_state_e             : mul/div execute occupancy states
//   REG_AW_DEFAULT         : default register address width
package mips_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mips_md_occupancy.sv
// Mul/div execute-stage occupancy tracker.
// A mul/div op entering E keeps E busy for MD_LAT cycles in total; a data
// memory wait freezes both the state and the latency counter.
// Ports:
//   clk        pipeline clock
//   rst        asynchronous active-low reset
//   md_start_e E holds a mul/div op
//   mem_wait   data memory is stalling the pipeline
//   md_busy    mul/div occupies E this cycle
//   state      current occupancy state
module mips_md_occupancy
  import mips_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      md_start_e,
  input  logic      mem_wait,
  output logic      md_busy,
  output md_state_e state
);

  localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  // The start cycle itself is the first busy cycle and the cnt==0 cycle is
  // the last, so the counter is loaded with MD_LAT-2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

  md_state_e        stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    md_busy   = 1'b0;
    case (state)
      MD_IDLE: begin
        md_busy = rst & md_start_e;
        if (md_start_e && !mem_wait) begin
          stateNext = MD_BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        md_busy = rst;
        if (!mem_wait) begin
          if (cnt == '0) begin
            stateNext = MD_IDLE;
          end else begin
            cntNext = cnt - 1'b1;
          end
        end
      end
      default: begin
        stateNext = MD_IDLE;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: operand forwarding,
// load-use and branch stalls, redirect flushes, mul/div execute occupancy
// and data-memory wait freezing.
// Optional build macro: HAZARD_PERF_EN adds the 32-bit stall_cnt port that
// counts cycles in which fetch is stalled.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   rs_d, rt_d, use_rs_d, use_rt_d decode sources and their use flags
//   branch_d, jump_d, pcsrc_d      decode control flow
//   rs_e, rt_e, wreg_e             execute sources / destination
//   regwrite_e, memread_e, md_start_e
//   wreg_m, wreg_w, regwrite_m, memtoreg_m, regwrite_w
//   mem_req_m, mem_ready_m         data memory handshake in M
//   stall_f/d/e/m, flush_d/e/m/w   pipeline register control
//   fwd_a_d, fwd_b_d               branch compare forward from M
//   fwd_a_e, fwd_b_e               ALU operand selects (FWD_RF/FWD_W/FWD_M)
//   md_busy                        mul/div occupying E
//   stall_cnt                      stall cycle counter (HAZARD_PERF_EN only)
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic              pcsrc_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic              regwrite_e,
  input  logic              memread_e,
  input  logic              md_start_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic              regwrite_w,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Register 0 is hard-wired zero, so it never produces a hazard.
  function automatic logic regMatch(input logic [REG_AW-1:0] dst,
                                    input logic              we,
                                    input logic [REG_AW-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  logic      memWait;
  logic      loadUse;
  logic      branchStall;
  logic      mdBusy;
  logic      redirectStall;
  logic [1:0] fwdAE;
  logic [1:0] fwdBE;
  md_state_e mdStateUnused;

  mips_md_occupancy #(
    .MD_LAT (MD_LAT)
  ) u_md (
    .clk        (clk),
    .rst        (rst),
    .md_start_e (md_start_e),
    .mem_wait   (memWait),
    .md_busy    (mdBusy),
    .state      (mdStateUnused)
  );

  assign memWait = mem_req_m & ~mem_ready_m;

  assign loadUse = memread_e &
                   ((use_rs_d & regMatch(wreg_e, regwrite_e, rs_d)) |
                    (use_rt_d & regMatch(wreg_e, regwrite_e, rt_d)));

  // A branch resolves in D, so it must wait for an E result or a loaded
  // value still in M; ALU results in M are forwarded instead.
  assign branchStall = branch_d &
                       (regMatch(wreg_e, regwrite_e, rs_d) |
                        regMatch(wreg_e, regwrite_e, rt_d) |
                        (memtoreg_m & (regMatch(wreg_m, regwrite_m, rs_d) |
                                       regMatch(wreg_m, regwrite_m, rt_d))));

  assign redirectStall = loadUse | branchStall;

  // M is the younger result, so it takes priority over W.
  assign fwdAE = regMatch(wreg_m, regwrite_m, rs_e) ? FWD_M :
                 regMatch(wreg_w, regwrite_w, rs_e) ? FWD_W : FWD_RF;
  assign fwdBE = regMatch(wreg_m, regwrite_m, rt_e) ? FWD_M :
                 regMatch(wreg_w, regwrite_w, rt_e) ? FWD_W : FWD_RF;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    md_busy = 1'b0;
    if (rst) begin
      stall_f = redirectStall | mdBusy | memWait;
      stall_d = stall_f;
      stall_e = mdBusy | memWait;
      stall_m = memWait;
      // A stalled stage is never flushed, and a memory wait suppresses
      // every flush except the bubble into W.
      flush_d = (pcsrc_d | jump_d) & ~stall_d & ~memWait;
      flush_e = redirectStall & ~stall_e & ~memWait;
      flush_m = mdBusy & ~stall_m & ~memWait;
      flush_w = memWait;
      fwd_a_d = regMatch(wreg_m, regwrite_m, rs_d);
      fwd_b_d = regMatch(wreg_m, regwrite_m, rt_d);
      fwd_a_e = fwdAE;
      fwd_b_e = fwdBE;
      md_busy = mdBusy;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_f) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
module tb_mips_hazard_ctrl;
  import mips_pkg::*;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic use_rs_d, use_rt_d, branch_d, jump_d, pcsrc_d;
  logic regwrite_e, memread_e, md_start_e;
  logic regwrite_m, memtoreg_m, regwrite_w, mem_req_m, mem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic fwd_a_d, fwd_b_d, md_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  mips_hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .jump_d(jump_d), .pcsrc_d(pcsrc_d),
    .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e),
    .regwrite_e(regwrite_e), .memread_e(memread_e), .md_start_e(md_start_e),
    .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .regwrite_w(regwrite_w),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic use_rs_d, use_rt_d, branch_d, jump_d, pcsrc_d;
    logic regwrite_e, memread_e, regwrite_m, memtoreg_m, regwrite_w;
    logic mem_req_m, mem_ready_m;
    logic [14:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int busyLeft = 0;            // cycles of mul/div occupancy still owed after this one
  int unsigned perfModel = 0;
  vec_t tbl[$];
  vec_t v;

  // {stall f,d,e,m, flush d,e,m,w, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy}
  function automatic logic [14:0] mkExp(input logic sf, sd, se, sm, fd, fe, fm, fw,
                                        input logic fad, fbd,
                                        input logic [1:0] fae, fbe,
                                        input logic busy);
    return {sf, sd, se, sm, fd, fe, fm, fw, fad, fbd, fae, fbe, busy};
  endfunction

  function automatic logic [14:0] dutVec();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
            fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy};
  endfunction

  function automatic vec_t zeroVec();
    vec_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic logic refMatch(input logic [REG_AW-1:0] dst, input logic we,
                                    input logic [REG_AW-1:0] src);
    return we && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] refSel(input logic [REG_AW-1:0] src);
    if (refMatch(wreg_m, regwrite_m, src)) return 2'b10;
    if (refMatch(wreg_w, regwrite_w, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the hazard rules, with mul/div occupancy tracked
  // as a simple count of remaining busy cycles.
  function automatic logic [14:0] modelOut();
    logic w, busy, lu, bs, sf, se, sm;
    if (!rst) return '0;
    w    = mem_req_m && !mem_ready_m;
    busy = (busyLeft > 0) || md_start_e;
    lu   = memread_e && ((use_rs_d && refMatch(wreg_e, regwrite_e, rs_d)) ||
                         (use_rt_d && refMatch(wreg_e, regwrite_e, rt_d)));
    bs   = branch_d && (refMatch(wreg_e, regwrite_e, rs_d) || refMatch(wreg_e, regwrite_e, rt_d) ||
                        (memtoreg_m && (refMatch(wreg_m, regwrite_m, rs_d) ||
                                        refMatch(wreg_m, regwrite_m, rt_d))));
    sf = lu || bs || busy || w;
    se = busy || w;
    sm = w;
    return mkExp(sf, sf, se, sm,
                 (pcsrc_d || jump_d) && !sf && !w,
                 (lu || bs) && !se && !w,
                 busy && !sm && !w,
                 w,
                 refMatch(wreg_m, regwrite_m, rs_d), refMatch(wreg_m, regwrite_m, rt_d),
                 refSel(rs_e), refSel(rt_e), busy);
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %015b expected %015b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model across a rising edge using the inputs present at it.
  task automatic tick();
    logic [14:0] o;
    @(posedge clk);
    o = modelOut();
    if (!rst) begin
      busyLeft  = 0;
      perfModel = 0;
    end else begin
      if (o[14]) perfModel++;
      if (!(mem_req_m && !mem_ready_m)) begin
        if (busyLeft > 0) busyLeft--;
        else if (md_start_e) busyLeft = MD_LAT - 1;
      end
    end
    #1;
  endtask

  task automatic cycle(input string name, input logic [14:0] exp);
    @(negedge clk);
    check(name, dutVec(), exp);
    tick();
  endtask

  task automatic applyVec(input vec_t a);
    rs_d = a.rs_d; rt_d = a.rt_d; use_rs_d = a.use_rs_d; use_rt_d = a.use_rt_d;
    branch_d = a.branch_d; jump_d = a.jump_d; pcsrc_d = a.pcsrc_d;
    rs_e = a.rs_e; rt_e = a.rt_e; wreg_e = a.wreg_e;
    regwrite_e = a.regwrite_e; memread_e = a.memread_e; md_start_e = 1'b0;
    wreg_m = a.wreg_m; wreg_w = a.wreg_w; regwrite_m = a.regwrite_m;
    memtoreg_m = a.memtoreg_m; regwrite_w = a.regwrite_w;
    mem_req_m = a.mem_req_m; mem_ready_m = a.mem_ready_m;
  endtask

  logic [14:0] busyExp, waitBusyExp, luExp;

  initial begin
    busyExp     = mkExp(1,1,1,0, 0,0,1,0, 0,0, 2'b00, 2'b00, 1);
    waitBusyExp = mkExp(1,1,1,1, 0,0,0,1, 0,0, 2'b00, 2'b00, 1);
    luExp       = mkExp(1,1,0,0, 0,1,0,0, 0,0, 2'b00, 2'b00, 0);

    // ---- combinational vectors, pipeline idle ----
    v = zeroVec(); v.rs_e = 3; v.wreg_m = 3; v.regwrite_m = 1; v.wreg_w = 3; v.regwrite_w = 1;
    v.exp = mkExp(0,0,0,0, 0,0,0,0, 0,0, 2'b10, 2'b00, 0); tbl.push_back(v);
    v.rs_e = 0; v.exp = '0; tbl.push_back(v);
    v = zeroVec(); v.rt_e = 4; v.wreg_w = 4; v.regwrite_w = 1; v.wreg_m = 4;
    v.exp = mkExp(0,0,0,0, 0,0,0,0, 0,0, 2'b00, 2'b01, 0); tbl.push_back(v);
    v = zeroVec(); v.memread_e = 1; v.regwrite_e = 1; v.wreg_e = 5; v.rs_d = 5; v.use_rs_d = 1;
    v.exp = luExp; tbl.push_back(v);
    v.use_rs_d = 0; v.exp = '0; tbl.push_back(v);
    v = zeroVec(); v.memread_e = 1; v.regwrite_e = 1; v.wreg_e = 6; v.rt_d = 6; v.use_rt_d = 1;
    v.exp = luExp; tbl.push_back(v);
    v = zeroVec(); v.memread_e = 1; v.regwrite_e = 1; v.use_rs_d = 1;
    v.exp = '0; tbl.push_back(v);
    v = zeroVec(); v.branch_d = 1; v.memtoreg_m = 1; v.regwrite_m = 1; v.wreg_m = 7; v.rt_d = 7;
    v.pcsrc_d = 1; v.exp = mkExp(1,1,0,0, 0,1,0,0, 0,1, 2'b00, 2'b00, 0); tbl.push_back(v);
    v = zeroVec(); v.pcsrc_d = 1; v.exp = mkExp(0,0,0,0, 1,0,0,0, 0,0, 2'b00, 2'b00, 0); tbl.push_back(v);
    v = zeroVec(); v.jump_d = 1; v.exp = mkExp(0,0,0,0, 1,0,0,0, 0,0, 2'b00, 2'b00, 0); tbl.push_back(v);
    v = zeroVec(); v.branch_d = 1; v.regwrite_e = 1; v.wreg_e = 2; v.rs_d = 2;
    v.exp = luExp; tbl.push_back(v);
    v.regwrite_e = 0; v.exp = '0; tbl.push_back(v);
    v = zeroVec(); v.wreg_m = 9; v.regwrite_m = 1; v.rs_d = 9;
    v.exp = mkExp(0,0,0,0, 0,0,0,0, 1,0, 2'b00, 2'b00, 0); tbl.push_back(v);
    v = zeroVec(); v.mem_req_m = 1; v.mem_ready_m = 0; v.jump_d = 1;
    v.memread_e = 1; v.regwrite_e = 1; v.wreg_e = 5; v.rs_d = 5; v.use_rs_d = 1;
    v.exp = mkExp(1,1,1,1, 0,0,0,1, 0,0, 2'b00, 2'b00, 0); tbl.push_back(v);
    v = zeroVec(); v.mem_req_m = 1; v.mem_ready_m = 1; v.exp = '0; tbl.push_back(v);

    // ---- reset: outputs forced low even with hazards on the inputs ----
    rst = 1'b0;
    applyVec(tbl[3]);
    md_start_e = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", dutVec(), '0);
    tick();
    rst = 1'b1;
    applyVec(zeroVec());

    for (int i = 0; i < tbl.size(); i++) begin
      applyVec(tbl[i]);
      cycle($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // ---- load-use then forward from M ----
    applyVec(tbl[3]);
    cycle("loaduse_stall", luExp);
    v = zeroVec(); v.memtoreg_m = 1; v.regwrite_m = 1; v.wreg_m = 5; v.rs_e = 5;
    applyVec(v);
    cycle("loaduse_fwd", mkExp(0,0,0,0, 0,0,0,0, 0,0, 2'b10, 2'b00, 0));

    // ---- mul/div occupancy: MD_LAT busy cycles from a one-cycle start ----
    applyVec(zeroVec());
    md_start_e = 1'b1;
    cycle("md_c0", busyExp);
    md_start_e = 1'b0;
    for (int k = 1; k < MD_LAT; k++) cycle($sformatf("md_c%0d", k), busyExp);
    cycle("md_done", '0);

    // ---- memory wait inside occupancy extends it ----
    md_start_e = 1'b1;
    cycle("mdw_c0", busyExp);
    md_start_e = 1'b0;
    cycle("mdw_c1", busyExp);
    mem_req_m = 1'b1;
    cycle("mdw_wait0", waitBusyExp);
    cycle("mdw_wait1", waitBusyExp);
    mem_req_m = 1'b0;
    cycle("mdw_c2", busyExp);
    cycle("mdw_c3", busyExp);
    cycle("mdw_done", '0);

    // ---- asynchronous reset in the middle of an occupancy ----
    md_start_e = 1'b1;
    cycle("rstmd_c0", busyExp);
    md_start_e = 1'b0;
    cycle("rstmd_c1", busyExp);
    check("rstmd_pre", dutVec(), busyExp);
    #2 rst = 1'b0;
    #1 check("rstmd_async", dutVec(), '0);
`ifdef HAZARD_PERF_EN
    check32("perf_reset", stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b1;
    cycle("rstmd_idle", '0);

    // ---- randomized traffic against the rule model ----
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      rs_d        = REG_AW'($urandom_range(0, 3));
      rt_d        = REG_AW'($urandom_range(0, 3));
      rs_e        = REG_AW'($urandom_range(0, 3));
      rt_e        = REG_AW'($urandom_range(0, 3));
      wreg_e      = REG_AW'($urandom_range(0, 3));
      wreg_m      = REG_AW'($urandom_range(0, 3));
      wreg_w      = REG_AW'($urandom_range(0, 3));
      use_rs_d    = $urandom_range(0, 1);
      use_rt_d    = $urandom_range(0, 1);
      branch_d    = ($urandom_range(0, 3) == 0);
      jump_d      = ($urandom_range(0, 5) == 0);
      pcsrc_d     = ($urandom_range(0, 3) == 0);
      regwrite_e  = $urandom_range(0, 1);
      memread_e   = $urandom_range(0, 1);
      md_start_e  = ($urandom_range(0, 5) == 0);
      regwrite_m  = $urandom_range(0, 1);
      memtoreg_m  = $urandom_range(0, 1);
      regwrite_w  = $urandom_range(0, 1);
      mem_req_m   = $urandom_range(0, 1);
      mem_ready_m = ($urandom_range(0, 2) != 0);
      cycle("rand", modelOut());
    end
    rst = 1'b1;
    applyVec(zeroVec());
    cycle("rand_tail", modelOut());

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    check32("perf_count", stall_cnt, 32'(perfModel));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
